// File: rtl/cpu_pkg.sv
// Constants shared by the fetch stage and the decode control unit.
// Covers the instruction field positions, the op encodings and the NOP word.
package cpu_pkg;
    localparam int XLEN     = 32;
    localparam int OP_HI    = 27;
    localparam int OP_LO    = 26;
    localparam int FUNCT_HI = 25;
    localparam int FUNCT_LO = 20;

    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'hE1A0_0000;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01
    } op_e;

    // Branch targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory port: address and enable out, read data one cycle later.
interface fetch_unit_if;
    import cpu_pkg::*;
    logic [XLEN-1:0] imem_addr;
    logic            imem_en;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_addr, output imem_en, input imem_rdata);
    modport slave  (input imem_addr, input imem_en, output imem_rdata);
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Fetch PC register: reset, then redirect (overrides stall), then stall, then +4.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    input  logic            stall,
    output logic [XLEN-1:0] pc_q
);
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q + XLEN'(4);
        if (redirect)
            pc_d = align_word(target);
        else if (stall)
            pc_d = pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous imem and presents
// the fetched word with its PC to decode, handling stall, flush and redirect.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] branch_target_e,
    fetch_unit_if.master    imem,
    output logic [XLEN-1:0] instr_d,
    output logic [1:0]      op_d,
    output logic [5:0]      funct_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus8_d,
    output logic            valid_d
);
    logic            stall_f_eff;
    logic [XLEN-1:0] pc_f;

    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic            hold_sel_q, hold_sel_d;
    logic [XLEN-1:0] hold_q, hold_d;

    // A decode stall must also freeze fetch, or the in-flight word is lost.
    assign stall_f_eff = stall_f | stall_d;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .redirect (pc_src_e),
        .target   (branch_target_e),
        .stall    (stall_f_eff),
        .pc_q     (pc_f)
    );

    assign imem.imem_addr = pc_f;
    assign imem.imem_en   = !rst && !stall_f_eff;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_pc_d    = rsp_pc_q;
        hold_sel_d  = hold_sel_q;
        hold_d      = hold_q;

        // Anything fetched while a flush or redirect is in flight is wrong-path.
        if (flush_d || pc_src_e) begin
            rsp_valid_d = 1'b0;
        end else if (!stall_d) begin
            rsp_valid_d = imem.imem_en;
            rsp_pc_d    = pc_f;
        end

        // The memory output only holds for one cycle after the read, so the
        // first stalled cycle snapshots it and later stalled cycles replay it.
        if (flush_d) begin
            hold_sel_d = 1'b0;
        end else if (stall_d) begin
            if (!hold_sel_q) begin
                hold_d     = imem.imem_rdata;
                hold_sel_d = 1'b1;
            end
        end else begin
            hold_sel_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= '0;
            hold_sel_q  <= 1'b0;
            hold_q      <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_pc_q    <= rsp_pc_d;
            hold_sel_q  <= hold_sel_d;
            hold_q      <= hold_d;
        end
    end

    assign instr_d    = !rsp_valid_q ? NOP_INSTR : (hold_sel_q ? hold_q : imem.imem_rdata);
    assign op_d       = instr_d[OP_HI:OP_LO];
    assign funct_d    = instr_d[FUNCT_HI:FUNCT_LO];
    assign valid_d    = rsp_valid_q;
    assign pc_d       = rsp_pc_q;
    assign pc_plus8_d = rsp_pc_q + XLEN'(8);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected decode slots are queued as stimulus is
// driven and popped/compared one cycle later against the DUT's decode outputs.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        rst, stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] branch_target_e;
    logic [31:0] instr_d, pc_d, pc_plus8_d;
    logic [1:0]  op_d;
    logic [5:0]  funct_d;
    logic        valid_d;

    logic        rst_w;
    logic [31:0] instr_w, pc_w, pc8_w;
    logic [1:0]  op_w;
    logic [5:0]  funct_w;
    logic        valid_w;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        string       tag;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fetch_unit_if imem_bus ();
    fetch_unit_if imem_bus_w ();

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .pc_src_e(pc_src_e), .branch_target_e(branch_target_e), .imem(imem_bus),
        .instr_d(instr_d), .op_d(op_d), .funct_d(funct_d), .pc_d(pc_d),
        .pc_plus8_d(pc_plus8_d), .valid_d(valid_d)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst_w), .stall_f(1'b0), .stall_d(1'b0), .flush_d(1'b0),
        .pc_src_e(1'b0), .branch_target_e(32'h0), .imem(imem_bus_w),
        .instr_d(instr_w), .op_d(op_w), .funct_d(funct_w), .pc_d(pc_w),
        .pc_plus8_d(pc8_w), .valid_d(valid_w)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h0A50_0000;
    endfunction

    // Synchronous memory; when not enabled the output is scrambled.
    always @(posedge clk) begin
        imem_bus.imem_rdata   <= imem_bus.imem_en   ? word(imem_bus.imem_addr)   : $urandom;
        imem_bus_w.imem_rdata <= imem_bus_w.imem_en ? word(imem_bus_w.imem_addr) : $urandom;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v, input logic [31:0] pc, input string tag);
        exp_t e;
        e.v = v; e.pc = pc; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic check_d();
        exp_t        e;
        logic [31:0] ins;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
            return;
        end
        e   = exp_q.pop_front();
        ins = e.v ? word(e.pc) : NOP;
        chk({e.tag, ".valid"}, {31'b0, valid_d}, {31'b0, e.v});
        chk({e.tag, ".instr"}, instr_d, ins);
        chk({e.tag, ".op"}, {30'b0, op_d}, {30'b0, ins[27:26]});
        chk({e.tag, ".funct"}, {26'b0, funct_d}, {26'b0, ins[25:20]});
        if (e.v) begin
            chk({e.tag, ".pc"}, pc_d, e.pc);
            chk({e.tag, ".pc8"}, pc_plus8_d, e.pc + 32'd8);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_d();
    endtask

    task automatic step_w(input logic [31:0] pc, input logic [31:0] pc8, input string tag);
        logic [31:0] ins;
        @(posedge clk);
        #1;
        ins = word(pc);
        chk({tag, ".valid"}, {31'b0, valid_w}, 32'd1);
        chk({tag, ".pc"}, pc_w, pc);
        chk({tag, ".pc8"}, pc8_w, pc8);
        chk({tag, ".instr"}, instr_w, ins);
        chk({tag, ".fields"}, {24'b0, op_w, funct_w}, {24'b0, ins[27:20]});
    endtask

    initial begin
        rst = 1'b1; rst_w = 1'b1;
        stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0;
        branch_target_e = 32'h0;

        // Reset state
        @(posedge clk); #1;
        push(1'b0, 32'h0, "rst"); step();
        chk("rst.pc_d", pc_d, 32'h0);
        chk("rst.en", {31'b0, imem_bus.imem_en}, 32'd0);
        chk("rst.addr", imem_bus.imem_addr, 32'h0);

        // Free run
        rst = 1'b0; #1;
        chk("run.en", {31'b0, imem_bus.imem_en}, 32'd1);
        push(1'b1, 32'h0, "run0"); step();
        push(1'b1, 32'h4, "run4"); step();
        push(1'b1, 32'h8, "run8"); step();

        // Three-cycle decode stall with scrambled memory output
        stall_d = 1'b1; #1;
        chk("stall.en", {31'b0, imem_bus.imem_en}, 32'd0);
        chk("stall.addr", imem_bus.imem_addr, 32'hC);
        push(1'b1, 32'h8, "stall1"); step();
        push(1'b1, 32'h8, "stall2"); step();
        push(1'b1, 32'h8, "stall3"); step();
        stall_d = 1'b0;
        push(1'b1, 32'hC, "rel12"); step();
        push(1'b1, 32'h10, "rel16"); step();

        // Redirect with flush to an unaligned target
        pc_src_e = 1'b1; flush_d = 1'b1; branch_target_e = 32'h0000_0103;
        push(1'b0, 32'h0, "redir"); step();
        pc_src_e = 1'b0; flush_d = 1'b0; #1;
        chk("redir.addr", imem_bus.imem_addr, 32'h100);
        push(1'b1, 32'h100, "tgt100"); step();
        push(1'b1, 32'h104, "tgt104"); step();

        // Redirect beats fetch stall
        stall_f = 1'b1; pc_src_e = 1'b1; branch_target_e = 32'h200; #1;
        chk("sf.en", {31'b0, imem_bus.imem_en}, 32'd0);
        push(1'b0, 32'h0, "sf_redir"); step();
        stall_f = 1'b0; pc_src_e = 1'b0;
        chk("sf.addr", imem_bus.imem_addr, 32'h200);
        push(1'b1, 32'h200, "tgt200"); step();
        push(1'b1, 32'h204, "tgt204"); step();

        // Flush beats decode stall
        stall_d = 1'b1;
        push(1'b1, 32'h204, "hold204"); step();
        flush_d = 1'b1;
        push(1'b0, 32'h0, "fl_st"); step();
        chk("fl_st.hold_sel", {31'b0, dut.hold_sel_q}, 32'd0);
        flush_d = 1'b0; stall_d = 1'b0;
        push(1'b1, 32'h208, "after_fl"); step();

        // Reset in the middle of a stall
        stall_d = 1'b1;
        push(1'b1, 32'h208, "pre_rst"); step();
        rst = 1'b1; #1;
        chk("mrst.en", {31'b0, imem_bus.imem_en}, 32'd0);
        push(1'b0, 32'h0, "mrst"); step();
        chk("mrst.pc_d", pc_d, 32'h0);
        chk("mrst.addr", imem_bus.imem_addr, 32'h0);
        rst = 1'b0; stall_d = 1'b0; #1;
        chk("mrst.en_rel", {31'b0, imem_bus.imem_en}, 32'd1);
        push(1'b1, 32'h0, "refetch0"); step();
        push(1'b1, 32'h4, "refetch4"); step();

        // Address wrap from a high reset vector
        rst_w = 1'b0;
        step_w(32'hFFFF_FFF8, 32'h0000_0000, "wrapF8");
        step_w(32'hFFFF_FFFC, 32'h0000_0004, "wrapFC");
        step_w(32'h0000_0000, 32'h0000_0008, "wrap00");
        step_w(32'h0000_0004, 32'h0000_000C, "wrap04");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
